// File: rtl/gshare_predictor.sv
// gshare next-PC predictor: PC XOR speculative global history indexes a table of
// saturating counters; history is repaired from ROB snapshots on mispredict.
module gshare_predictor #(
  parameter int INDEX_BITS = 8,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,

  input  logic                valid_from_inst_fetcher,
  input  logic [31:0]         inst_from_inst_fetcher,
  input  logic [31:0]         pc_from_inst_fetcher,
  output logic [31:0]         next_pc_to_inst_fetcher,
  output logic                pred_taken_to_inst_fetcher,
  output logic [GHR_BITS-1:0] ghr_to_inst_fetcher,

  input  logic                valid_from_rob_bus,
  input  logic [31:0]         pc_from_rob_bus,
  input  logic                is_taken_from_rob_bus,
  input  logic [GHR_BITS-1:0] ghr_from_rob_bus,
  input  logic                mispredict_from_rob_bus,

  output logic                init_done
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   init_ptr_q, init_ptr_d;
  logic [GHR_BITS-1:0]     ghr_q, ghr_d;

  // Counter table has no reset; the INIT walk is what clears it.
  logic [CTR_BITS-1:0]     pht_q [ENTRIES];
  logic                    pht_we;
  logic [INDEX_BITS-1:0]   pht_waddr;
  logic [CTR_BITS-1:0]     pht_wdata;

  // ---------------------------------------------------------------- fetch side
  logic [6:0]              fetch_opcode;
  logic                    fetch_is_jal;
  logic                    fetch_is_branch;
  logic [INDEX_BITS-1:0]   fetch_ghr_ext;
  logic [INDEX_BITS-1:0]   fetch_idx;
  logic [CTR_BITS-1:0]     fetch_ctr;
  logic                    fetch_dir_taken;
  logic [31:0]             imm_j;
  logic [31:0]             imm_b;

  assign fetch_opcode    = inst_from_inst_fetcher[6:0];
  assign fetch_is_jal    = (fetch_opcode == OP_JAL);
  assign fetch_is_branch = (fetch_opcode == OP_BRANCH);
  assign fetch_ghr_ext   = INDEX_BITS'(ghr_q);
  assign fetch_idx       = pc_from_inst_fetcher[INDEX_BITS+1:2] ^ fetch_ghr_ext;
  assign fetch_ctr       = pht_q[fetch_idx];
  assign fetch_dir_taken = (state_q == ST_RUN) && fetch_ctr[CTR_BITS-1];

  assign imm_j = {{12{inst_from_inst_fetcher[31]}},
                  inst_from_inst_fetcher[19:12],
                  inst_from_inst_fetcher[20],
                  inst_from_inst_fetcher[30:21],
                  1'b0};
  assign imm_b = {{20{inst_from_inst_fetcher[31]}},
                  inst_from_inst_fetcher[7],
                  inst_from_inst_fetcher[30:25],
                  inst_from_inst_fetcher[11:8],
                  1'b0};

  always_comb begin
    pred_taken_to_inst_fetcher = fetch_is_branch && fetch_dir_taken;
    if (fetch_is_jal) begin
      next_pc_to_inst_fetcher = pc_from_inst_fetcher + imm_j;
    end else if (pred_taken_to_inst_fetcher) begin
      next_pc_to_inst_fetcher = pc_from_inst_fetcher + imm_b;
    end else begin
      next_pc_to_inst_fetcher = pc_from_inst_fetcher + 32'd4;
    end
  end

  assign ghr_to_inst_fetcher = ghr_q;
  assign init_done           = (state_q == ST_RUN);

  // ---------------------------------------------------------------- commit side
  logic [INDEX_BITS-1:0]   commit_ghr_ext;
  logic [INDEX_BITS-1:0]   commit_idx;
  logic [CTR_BITS-1:0]     commit_ctr;
  logic [CTR_BITS-1:0]     commit_ctr_next;

  assign commit_ghr_ext = INDEX_BITS'(ghr_from_rob_bus);
  assign commit_idx     = pc_from_rob_bus[INDEX_BITS+1:2] ^ commit_ghr_ext;
  assign commit_ctr     = pht_q[commit_idx];

  always_comb begin
    commit_ctr_next = commit_ctr;
    if (is_taken_from_rob_bus) begin
      if (commit_ctr != CTR_MAX) commit_ctr_next = commit_ctr + CTR_BITS'(1);
    end else begin
      if (commit_ctr != CTR_MIN) commit_ctr_next = commit_ctr - CTR_BITS'(1);
    end
  end

  // History shift candidates; a 1-bit history simply becomes the new bit.
  logic [GHR_BITS-1:0]     ghr_repair;
  logic [GHR_BITS-1:0]     ghr_fetch_shift;

  generate
    if (GHR_BITS == 1) begin : g_ghr_one
      assign ghr_repair      = is_taken_from_rob_bus;
      assign ghr_fetch_shift = pred_taken_to_inst_fetcher;
    end else begin : g_ghr_wide
      assign ghr_repair      = {ghr_from_rob_bus[GHR_BITS-2:0], is_taken_from_rob_bus};
      assign ghr_fetch_shift = {ghr_q[GHR_BITS-2:0], pred_taken_to_inst_fetcher};
    end
  endgenerate

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    pht_we     = 1'b0;
    pht_waddr  = init_ptr_q;
    pht_wdata  = CTR_WNT;

    if (rdy) begin
      case (state_q)
        ST_INIT: begin
          pht_we     = 1'b1;
          init_ptr_d = init_ptr_q + INDEX_BITS'(1);
          if (init_ptr_q == '1) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (valid_from_rob_bus) begin
            pht_we    = 1'b1;
            pht_waddr = commit_idx;
            pht_wdata = commit_ctr_next;
          end
          // A repair overrides any speculative shift from the same cycle.
          if (valid_from_rob_bus && mispredict_from_rob_bus) begin
            ghr_d = ghr_repair;
          end else if (valid_from_inst_fetcher && fetch_is_branch) begin
            ghr_d = ghr_fetch_shift;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
  end

  logic unused_rob_pc_bits;
  assign unused_rob_pc_bits = ^{pc_from_rob_bus[31:INDEX_BITS+2], pc_from_rob_bus[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: expected fetch results are queued when a
// fetch is driven and popped/compared once the combinational outputs settle.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        valid_f;
  logic [31:0] inst_f;
  logic [31:0] pc_f;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [7:0]  ghr_out;
  logic        valid_r;
  logic [31:0] pc_r;
  logic        taken_r;
  logic [7:0]  ghr_r;
  logic        mis_r;
  logic        init_done;

  always #5 clk = ~clk;

  gshare_predictor #(.INDEX_BITS(8), .CTR_BITS(2), .GHR_BITS(8)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .rdy                        (rdy),
    .valid_from_inst_fetcher    (valid_f),
    .inst_from_inst_fetcher     (inst_f),
    .pc_from_inst_fetcher       (pc_f),
    .next_pc_to_inst_fetcher    (next_pc),
    .pred_taken_to_inst_fetcher (pred_taken),
    .ghr_to_inst_fetcher        (ghr_out),
    .valid_from_rob_bus         (valid_r),
    .pc_from_rob_bus            (pc_r),
    .is_taken_from_rob_bus      (taken_r),
    .ghr_from_rob_bus           (ghr_r),
    .mispredict_from_rob_bus    (mis_r),
    .init_done                  (init_done)
  );

  typedef struct {
    string       tag;
    logic [31:0] npc;
    logic        taken;
    logic [7:0]  ghr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [31:0] off);
    return {off[12], off[10:5], 5'd0, 5'd0, 3'd0, off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] off);
    return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'b1101111};
  endfunction

  task automatic drive_fetch(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    valid_f = v;
    pc_f    = pc;
    inst_f  = inst;
  endtask

  task automatic drive_rob(input logic [31:0] pc, input logic t, input logic [7:0] g, input logic m);
    valid_r = 1'b1;
    pc_r    = pc;
    taken_r = t;
    ghr_r   = g;
    mis_r   = m;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] npc, input logic t, input logic [7:0] g);
    exp_t e;
    exp_t o;
    e.tag = tag; e.npc = npc; e.taken = t; e.ghr = g;
    sb_q.push_back(e);
    #1;
    o = sb_q.pop_front();
    check({o.tag, ".npc"},   next_pc,    o.npc);
    check({o.tag, ".taken"}, pred_taken, {31'd0, o.taken});
    check({o.tag, ".ghr"},   ghr_out,    {24'd0, o.ghr});
    $display("txn %-18s pc=%08h npc=%08h taken=%0b ghr=%02h", o.tag, pc_f, next_pc, pred_taken, ghr_out);
  endtask

  task automatic step();
    @(negedge clk);
    valid_f = 1'b0;
    valid_r = 1'b0;
    mis_r   = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic t, input logic [7:0] g, input logic m);
    drive_rob(pc, t, g, m);
    step();
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] npc, input logic t, input logic [7:0] g);
    drive_fetch(1'b0, pc, inst);
    expect_out(tag, npc, t, g);
  endtask

  logic [31:0] br16, brm32, jalm8;

  initial begin
    br16  = enc_b(32'd16);
    brm32 = enc_b(-32'sd32);
    jalm8 = enc_j(-32'sd8);
    rst_n = 1'b0; rdy = 1'b1;
    valid_f = 1'b0; pc_f = '0; inst_f = '0;
    valid_r = 1'b0; pc_r = '0; taken_r = 1'b0; ghr_r = '0; mis_r = 1'b0;

    #2;
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_ghr", {24'd0, ghr_out}, 32'd0);
    probe("rst_branch", 32'h100, br16, 32'h104, 1'b0, 8'h00);
    probe("rst_jal", 32'h1000, jalm8, 32'h0FF8, 1'b0, 8'h00);

    // First walk: rdy held high, init_done after exactly 256 edges.
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      if (k == 0 || k == 128 || k == 255) begin
        drive_fetch(1'b1, 32'h100, br16);
        expect_out($sformatf("init_br_k%0d", k), 32'h104, 1'b0, 8'h00);
      end
      if (k == 255) check("init_done_k255", {31'd0, init_done}, 32'd0);
      if (k == 256) check("init_done_k256", {31'd0, init_done}, 32'd1);
      if (k < 256) step();
    end

    // Single taken commit flips weak-not-taken to weak-taken.
    probe("pc40_before", 32'h40, br16, 32'h44, 1'b0, 8'h00);
    commit(32'h40, 1'b1, 8'h00, 1'b0);
    probe("pc40_after", 32'h40, br16, 32'h50, 1'b1, 8'h00);

    // Saturation in both directions at pc 0x80.
    for (int i = 0; i < 5; i++) commit(32'h80, 1'b1, 8'h00, 1'b0);
    probe("sat_5T", 32'h80, br16, 32'h90, 1'b1, 8'h00);
    commit(32'h80, 1'b0, 8'h00, 1'b0);
    probe("sat_5T_1NT", 32'h80, br16, 32'h90, 1'b1, 8'h00);
    commit(32'h80, 1'b0, 8'h00, 1'b0);
    probe("sat_5T_2NT", 32'h80, br16, 32'h84, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) commit(32'h80, 1'b0, 8'h00, 1'b0);
    probe("sat_5NT", 32'h80, br16, 32'h84, 1'b0, 8'h00);
    commit(32'h80, 1'b1, 8'h00, 1'b0);
    probe("sat_5NT_1T", 32'h80, br16, 32'h84, 1'b0, 8'h00);
    commit(32'h80, 1'b1, 8'h00, 1'b0);
    probe("sat_5NT_2T", 32'h80, br16, 32'h90, 1'b1, 8'h00);

    // Backward branch target.
    commit(32'h300, 1'b1, 8'h00, 1'b0);
    probe("neg_branch", 32'h300, brm32, 32'h2E0, 1'b1, 8'h00);

    // rdy low: outputs stay live, commit and repair are ignored.
    rdy = 1'b0;
    probe("rdy0_live", 32'h40, br16, 32'h50, 1'b1, 8'h00);
    commit(32'hC0, 1'b1, 8'h7F, 1'b1);
    rdy = 1'b1;
    probe("rdy0_frozen", 32'hC0, br16, 32'hC4, 1'b0, 8'h00);

    // Three not-taken branch fetches shift in zeros.
    for (int i = 0; i < 3; i++) begin
      drive_fetch(1'b1, 32'h200, br16);
      expect_out($sformatf("ghr_nt_%0d", i), 32'h204, 1'b0, 8'h00);
      step();
    end
    probe("ghr_after_3nt", 32'h200, br16, 32'h204, 1'b0, 8'h00);

    // Repair wins over a simultaneous fetch shift.
    drive_fetch(1'b1, 32'h200, br16);
    drive_rob(32'h400, 1'b1, 8'h05, 1'b1);
    expect_out("repair_cycle", 32'h204, 1'b0, 8'h00);
    step();
    probe("repair_ghr", 32'h200, br16, 32'h204, 1'b0, 8'h0B);

    // Train index 0x80^0x0B, then a taken fetch shifts in a one.
    commit(32'h200, 1'b1, 8'h0B, 1'b0);
    drive_fetch(1'b1, 32'h200, br16);
    expect_out("shift1_cycle", 32'h210, 1'b1, 8'h0B);
    step();
    probe("shift1_ghr", 32'h200, br16, 32'h204, 1'b0, 8'h17);

    // JAL and a non-branch leave the history alone.
    drive_fetch(1'b1, 32'h1000, jalm8);
    expect_out("jal_cycle", 32'h0FF8, 1'b0, 8'h17);
    step();
    drive_fetch(1'b1, 32'h2000, 32'h00000013);
    expect_out("addi_cycle", 32'h2004, 1'b0, 8'h17);
    step();
    probe("jal_ghr_hold", 32'h1000, jalm8, 32'h0FF8, 1'b0, 8'h17);

    // Drive history to 0xA5 through a repair.
    commit(32'h600, 1'b1, 8'h52, 1'b1);
    probe("ghr_a5", 32'h100, br16, 32'h104, 1'b0, 8'hA5);

    // Asynchronous reset takes effect between clock edges.
    rst_n = 1'b0;
    #1;
    check("async_rst_ghr", {24'd0, ghr_out}, 32'd0);
    check("async_rst_init_done", {31'd0, init_done}, 32'd0);
    probe("async_rst_pc40", 32'h40, br16, 32'h44, 1'b0, 8'h00);
    step();
    rst_n = 1'b1;

    // Second walk: 10 rdy-low edges stretch it; an update mid-walk is dropped.
    for (int k = 0; k <= 266; k++) begin
      if (k == 0) probe("init2_pc40", 32'h40, br16, 32'h44, 1'b0, 8'h00);
      if (k == 50) rdy = 1'b0;
      if (k == 60) rdy = 1'b1;
      if (k == 100) drive_rob(32'h40, 1'b1, 8'h03, 1'b1);
      if (k == 265) check("init2_done_k265", {31'd0, init_done}, 32'd0);
      if (k == 266) check("init2_done_k266", {31'd0, init_done}, 32'd1);
      if (k < 266) step();
    end
    probe("post_init_ignored", 32'h40, br16, 32'h44, 1'b0, 8'h00);
    commit(32'h40, 1'b1, 8'h00, 1'b0);
    probe("post_init_weak", 32'h40, br16, 32'h50, 1'b1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
